stopwatch_result_gen: RTL and testbench
=======================================

// Module: stopwatch_result_gen
// PURPOSE
//  Timing core that produces the 22-bit run times the leaderboard ranks. Counts
//  milliseconds while a run is active and latches the finished time plus the run
//  mode (slow/fast). Holds the result on a valid/ack handshake until the
//  leaderboard side consumes it. Also drives a live time value for the 7-seg path.
// PARAMETERS
//  TICK_DIV  100_000  clk cycles per 1 ms tick (100 MHz board); benches use 4
//  TIME_W    22       width of time values, in ms (max 4_194_303 ms)
// PORTS
//  clk           in   1       system clock, single clock domain
//  reset         in   1       asynchronous, active-high reset
//  start_btn     in   1       1-cycle debounced pulse: begin run
//  stop_btn      in   1       1-cycle pulse: end run, report time
//  pause_btn     in   1       1-cycle pulse: toggle RUNNING/PAUSED
//  clear_btn     in   1       1-cycle pulse: abort run, no report
//  mode_sel      in   2       01 = slow run, 10 = fast run; 00/11 invalid
//  result_ack    in   1       consumer has taken result (level, sampled on clk)
//  live_time     out  TIME_W  current count, for display
//  result_time   out  TIME_W  latched finished time
//  result_mode   out  2       mode latched at start (01/10)
//  result_valid  out  1       result_time/result_mode valid
//  running       out  1       1 in RUNNING
//  overflow      out  1       count saturated during current/last run
// BEHAVIOUR
//  Reset (async): state IDLE; all outputs 0; prescaler 0.
//  States: IDLE, RUNNING, PAUSED, REPORT. Button priority same cycle:
//   clear > stop > pause > start.
//  IDLE: start_btn with valid mode_sel -> RUNNING next edge; live_time<=0,
//   overflow<=0, prescaler<=0, mode latched. Invalid mode_sel: start ignored.
//   stop/pause ignored in IDLE.
//  RUNNING: prescaler counts 0..TICK_DIV-1; tick when ==TICK_DIV-1; live_time+1
//   on the edge after tick. First increment exactly TICK_DIV cycles after entry.
//   live_time saturates at 2^TIME_W-1, sets overflow (sticky until next start).
//   pause_btn -> PAUSED (prescaler and count frozen). stop_btn -> REPORT.
//  PAUSED: pause_btn -> RUNNING, prescaler resumes from frozen value;
//   stop_btn -> REPORT; start_btn ignored.
//  Stop latency: stop in cycle m -> result_time = live_time value of cycle m
//   (a tick coincident with stop is discarded), result_valid=1 from edge m+1.
//  REPORT: result_valid held 1, result_time/result_mode stable. result_ack high
//   while valid -> valid 0 and IDLE next edge. start_btn ignored until ack.
//   live_time keeps showing the final time until next start.
//  clear_btn any state -> IDLE next edge, result_valid 0, live_time 0, no report;
//   in REPORT clear drops the pending result.
//  result_ack outside REPORT: no effect. Zero-length run (stop on first RUNNING
//   cycle) reports 0.
//  Reset mid-run or mid-REPORT: all state lost, valid deasserts immediately.
// STRUCTURE
//  Shared package sw_pkg: TIME_W, MODE_SLOW=2'b01, MODE_FAST=2'b10, state enc.
//  Sub-module ms_tick_gen (prescaler; inputs en, clr; output 1-cycle tick).
//  Top holds FSM, saturating counter, result registers.
// TESTING (TICK_DIV=4)
//  1 mode=01, start, wait 40 cycles, stop -> result_time=10, result_mode=01,
//    valid from next edge, held until ack; after ack valid=0, running=0.
//  2 mode=10, start, 8 cyc, pause, 20 cyc, pause, 8 cyc, stop -> result_time=4.
//  3 mode=00, start -> stays IDLE, running=0, live_time=0.
//  4 start, stop+clear same cycle -> IDLE, no valid; stop+pause -> REPORT.
//  5 preload count 2^22-2 (force), run 12 cyc -> live_time=4_194_303, overflow=1,
//    reported time 4_194_303.
//  6 reset asserted mid-REPORT -> result_valid, running, live_time 0 same cycle.

Source files
------------

// File: rtl/sw_pkg.sv
// Shared definitions for the stopwatch result generator: time width, run modes
// and FSM state encoding.
package sw_pkg;

  localparam int TIME_W = 22;

  localparam logic [1:0] MODE_SLOW = 2'b01;
  localparam logic [1:0] MODE_FAST = 2'b10;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUNNING = 2'd1;
  localparam logic [1:0] ST_PAUSED  = 2'd2;
  localparam logic [1:0] ST_REPORT  = 2'd3;

  function automatic logic mode_is_valid(input logic [1:0] mode);
    return (mode == MODE_SLOW) || (mode == MODE_FAST);
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: counts enabled cycles and pulses tick on the last one
// of every TICK_DIV. Holds its phase while en is low so a paused run resumes cleanly.
module ms_tick_gen #(
  parameter int TICK_DIV = 100_000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_count;

  assign tick = en && (r_count == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= tick ? '0 : r_count + 1'b1;
    end
  end

endmodule

// File: rtl/stopwatch_result_gen.sv
// Stopwatch timing core: run/pause/stop FSM, saturating millisecond counter and
// a result register held on a valid/ack handshake for the leaderboard.
module stopwatch_result_gen
  import sw_pkg::*;
#(
  parameter int TICK_DIV = 100_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_btn,
  input  logic              stop_btn,
  input  logic              pause_btn,
  input  logic              clear_btn,
  input  logic [1:0]        mode_sel,
  input  logic              result_ack,
  output logic [TIME_W-1:0] live_time,
  output logic [TIME_W-1:0] result_time,
  output logic [1:0]        result_mode,
  output logic              result_valid,
  output logic              running,
  output logic              overflow
);

  localparam logic [TIME_W-1:0] TIME_MAX = '1;

  logic [1:0]        r_state;
  logic [1:0]        r_mode;
  logic [TIME_W-1:0] r_live_time;
  logic [TIME_W-1:0] r_result_time;
  logic [1:0]        r_result_mode;
  logic              r_result_valid;
  logic              r_overflow;

  logic w_start_ok;
  logic w_run_quiet;
  logic w_tick;

  assign w_start_ok = (r_state == ST_IDLE) && start_btn && !clear_btn && mode_is_valid(mode_sel);

  // The prescaler only advances on RUNNING cycles with no button action, so a
  // tick coinciding with stop or pause is dropped rather than half-applied.
  assign w_run_quiet = (r_state == ST_RUNNING) && !clear_btn && !stop_btn && !pause_btn;

  ms_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .en   (w_run_quiet),
    .clr  (w_start_ok),
    .tick (w_tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_mode         <= '0;
      r_live_time    <= '0;
      r_result_time  <= '0;
      r_result_mode  <= '0;
      r_result_valid <= 1'b0;
      r_overflow     <= 1'b0;
    end else if (clear_btn) begin
      r_state        <= ST_IDLE;
      r_live_time    <= '0;
      r_result_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start_ok) begin
            r_state     <= ST_RUNNING;
            r_live_time <= '0;
            r_overflow  <= 1'b0;
            r_mode      <= mode_sel;
          end
        end
        ST_RUNNING: begin
          if (stop_btn) begin
            r_state        <= ST_REPORT;
            r_result_time  <= r_live_time;
            r_result_mode  <= r_mode;
            r_result_valid <= 1'b1;
          end else if (pause_btn) begin
            r_state <= ST_PAUSED;
          end else if (w_tick) begin
            if (r_live_time == TIME_MAX) begin
              r_overflow <= 1'b1;
            end else begin
              r_live_time <= r_live_time + 1'b1;
            end
          end
        end
        ST_PAUSED: begin
          if (stop_btn) begin
            r_state        <= ST_REPORT;
            r_result_time  <= r_live_time;
            r_result_mode  <= r_mode;
            r_result_valid <= 1'b1;
          end else if (pause_btn) begin
            r_state <= ST_RUNNING;
          end
        end
        ST_REPORT: begin
          if (result_ack) begin
            r_state        <= ST_IDLE;
            r_result_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign live_time    = r_live_time;
  assign result_time  = r_result_time;
  assign result_mode  = r_result_mode;
  assign result_valid = r_result_valid;
  assign running      = (r_state == ST_RUNNING);
  assign overflow     = r_overflow;

endmodule

// File: tb/tb_stopwatch_result_gen.sv
// Self-checking bench for stopwatch_result_gen: directed scenarios plus a random
// phase, all compared against a cycle-level behavioural model of the stopwatch.
module tb_stopwatch_result_gen;

  localparam int TICK_DIV = 4;
  localparam int TIME_W   = 22;
  localparam int MAXV     = (1 << TIME_W) - 1;

  localparam int M_IDLE   = 0;
  localparam int M_RUN    = 1;
  localparam int M_PAUSE  = 2;
  localparam int M_REPORT = 3;

  logic              clk;
  logic              reset;
  logic              startBtn, stopBtn, pauseBtn, clearBtn, resultAck;
  logic [1:0]        modeSel;
  logic [TIME_W-1:0] liveTime, resultTime;
  logic [1:0]        resultMode;
  logic              resultValid, running, overflow;

  int vecCount  = 0;
  int missCount = 0;

  // Model: elapsed ms is the number of quiet running cycles divided by TICK_DIV,
  // offset by a base that only changes when the count is preloaded.
  int         mState, mBase, mActive, mResTime;
  logic [1:0] mMode, mResMode;
  logic       mValid, mOvf;

  stopwatch_result_gen #(
    .TICK_DIV(TICK_DIV)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start_btn   (startBtn),
    .stop_btn    (stopBtn),
    .pause_btn   (pauseBtn),
    .clear_btn   (clearBtn),
    .mode_sel    (modeSel),
    .result_ack  (resultAck),
    .live_time   (liveTime),
    .result_time (resultTime),
    .result_mode (resultMode),
    .result_valid(resultValid),
    .running     (running),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int modelLive();
    int sum;
    sum = mBase + mActive / TICK_DIV;
    return (sum > MAXV) ? MAXV : sum;
  endfunction

  task automatic modelReset();
    mState = M_IDLE; mBase = 0; mActive = 0; mResTime = 0;
    mMode = 2'b00; mResMode = 2'b00; mValid = 1'b0; mOvf = 1'b0;
  endtask

  task automatic modelEdge();
    int liveNow;
    liveNow = modelLive();
    if (clearBtn) begin
      mState = M_IDLE; mBase = 0; mActive = 0; mValid = 1'b0;
    end else begin
      case (mState)
        M_IDLE: begin
          if (startBtn && (modeSel == 2'b01 || modeSel == 2'b10)) begin
            mState = M_RUN; mBase = 0; mActive = 0; mOvf = 1'b0; mMode = modeSel;
          end
        end
        M_RUN, M_PAUSE: begin
          if (stopBtn) begin
            mState = M_REPORT; mResTime = liveNow; mResMode = mMode; mValid = 1'b1;
          end else if (pauseBtn) begin
            mState = (mState == M_RUN) ? M_PAUSE : M_RUN;
          end else if (mState == M_RUN) begin
            mActive++;
            if (mBase + mActive / TICK_DIV > MAXV) mOvf = 1'b1;
          end
        end
        default: begin
          if (resultAck) begin
            mState = M_IDLE; mValid = 1'b0;
          end
        end
      endcase
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vecCount++;
    assert (observed === expected)
    else begin
      missCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkModel();
    checkOutput("live_time", 32'(liveTime), 32'(modelLive()));
    checkOutput("result_time", 32'(resultTime), 32'(mResTime));
    checkOutput("result_mode", 32'(resultMode), 32'(mResMode));
    checkOutput("result_valid", 32'(resultValid), 32'(mValid));
    checkOutput("running", 32'(running), 32'(mState == M_RUN));
    checkOutput("overflow", 32'(overflow), 32'(mOvf));
  endtask

  // Drive one cycle of buttons, advance the model at the edge, compare just after.
  task automatic applyStimulus(input logic st, input logic sp, input logic pa,
                               input logic cl, input logic ak);
    startBtn = st; stopBtn = sp; pauseBtn = pa; clearBtn = cl; resultAck = ak;
    @(posedge clk);
    modelEdge();
    #1;
    checkModel();
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    startBtn = 1'b0; stopBtn = 1'b0; pauseBtn = 1'b0; clearBtn = 1'b0; resultAck = 1'b0;
    modeSel = 2'b00;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checkModel();
    checkOutput("reset_valid", 32'(resultValid), 0);

    // Slow run of 40 cycles reports 10 ms and holds until ack.
    modeSel = 2'b01;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idleCycles(40);
    checkOutput("t1_live", 32'(liveTime), 10);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("t1_valid", 32'(resultValid), 1);
    checkOutput("t1_time", 32'(resultTime), 10);
    checkOutput("t1_mode", 32'(resultMode), 1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("t1_hold", 32'(resultValid), 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("t1_ack_valid", 32'(resultValid), 0);
    checkOutput("t1_ack_running", 32'(running), 0);
    checkOutput("t1_live_kept", 32'(liveTime), 10);

    // Fast run with a pause in the middle counts only running time.
    modeSel = 2'b10;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idleCycles(8);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idleCycles(20);
    checkOutput("t2_paused_live", 32'(liveTime), 2);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idleCycles(8);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("t2_time", 32'(resultTime), 4);
    checkOutput("t2_mode", 32'(resultMode), 2);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Invalid modes never start a run.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    modeSel = 2'b00;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idleCycles(4);
    checkOutput("t3_running_00", 32'(running), 0);
    checkOutput("t3_live_00", 32'(liveTime), 0);
    modeSel = 2'b11;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idleCycles(4);
    checkOutput("t3_running_11", 32'(running), 0);

    // Clear beats stop; stop beats pause; zero-length run; clear drops a result.
    modeSel = 2'b01;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idleCycles(5);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("t4_clear_valid", 32'(resultValid), 0);
    checkOutput("t4_clear_live", 32'(liveTime), 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idleCycles(6);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("t4_stop_pause_valid", 32'(resultValid), 1);
    checkOutput("t4_stop_pause_time", 32'(resultTime), 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("t4_zero_time", 32'(resultTime), 0);
    checkOutput("t4_zero_valid", 32'(resultValid), 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("t4_drop_valid", 32'(resultValid), 0);

    // Preload near full scale while paused, then run into saturation.
    modeSel = 2'b10;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    force dut.r_live_time = TIME_W'(MAXV - 1);
    @(negedge clk);
    release dut.r_live_time;
    mBase = (MAXV - 1) - mActive / TICK_DIV;
    idleCycles(2);
    checkOutput("t5_preload", 32'(liveTime), 32'(MAXV - 1));
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idleCycles(12);
    checkOutput("t5_sat_live", 32'(liveTime), 32'(MAXV));
    checkOutput("t5_overflow", 32'(overflow), 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("t5_sat_result", 32'(resultTime), 32'(MAXV));
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset in REPORT clears outputs without waiting for a clock edge.
    modeSel = 2'b01;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idleCycles(10);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("t6_pre_valid", 32'(resultValid), 1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("t6_valid", 32'(resultValid), 0);
    checkOutput("t6_running", 32'(running), 0);
    checkOutput("t6_live", 32'(liveTime), 0);
    modelReset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkModel();

    // Random button traffic against the model.
    for (int i = 0; i < 800; i++) begin
      modeSel = 2'($urandom_range(0, 3));
      applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 29) == 0,
                    $urandom_range(0, 19) == 0, $urandom_range(0, 59) == 0,
                    $urandom_range(0, 3) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
